// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demultiplexer.
// One upstream producer feeds four independent consumers. Each channel has a
// one-entry holding register, so a stalled consumer blocks only its own channel.
// A per-channel transfer counter records completed drain handshakes.
//
// Handshake rule on every port: a word moves on a rising clock edge exactly
// when valid and ready are both high on that edge. A producer holding valid
// high must keep its payload (and in_address) stable until it sees ready.
module demux4_stream #(
    parameter int WIDTH = 32,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_address,
    input  logic [WIDTH-1:0]   in_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [4*CW-1:0]    xfer_count
);

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [CW-1:0]    cnt_q  [4];
    logic [CW-1:0]    cnt_d  [4];

    logic       accept;
    logic [3:0] drain;

    // The addressed channel can take a word if it is empty or emptying now.
    always_comb begin
        in_ready = reset_n & ~flush & (~valid_q[in_address] | out_ready[in_address]);
        accept   = in_valid & in_ready;
        drain    = valid_q & out_ready;
    end

    // Next-state for channel buffers and counters; a load wins over a drain.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            valid_d[i] = valid_q[i] & ~drain[i];
            data_d[i]  = data_q[i];
            cnt_d[i]   = cnt_q[i] + CW'(drain[i]);
            if (accept && (in_address == 2'(i))) begin
                valid_d[i] = 1'b1;
                data_d[i]  = in_data;
            end
            // Flush empties every buffer but leaves data and counters alone.
            if (flush) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Channel state registers; reset discards every buffered word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // Outputs come straight from registers; nothing combinational from in_data.
    always_comb begin
        out_valid = valid_q;
        for (int i = 0; i < 4; i++) begin
            out_data[i*WIDTH +: WIDTH] = data_q[i];
            xfer_count[i*CW +: CW]     = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed plus randomized bench for demux4_stream.
// Reference model: one FIFO of expected words per channel, the last word
// delivered to each channel, and an integer drain count per channel.
module tb_demux4_stream;

  localparam int W  = 32;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_address;
  logic [W-1:0]   in_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic [4*CW-1:0] xfer_count;

  demux4_stream #(.WIDTH(W), .CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_address (in_address),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_count (xfer_count)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] mdata [4];
  int           mcnt  [4];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      mdata[i] = '0;
      mcnt[i]  = 0;
    end
  endfunction

  // Monitor: compare registered outputs, then retire words drained on the next edge.
  always @(negedge clk) begin
    logic [W-1:0] ed;
    for (int i = 0; i < 4; i++) begin
      ed = (exp_q[i].size() > 0) ? exp_q[i][0] : mdata[i];
      check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(exp_q[i].size() > 0));
      check($sformatf("out_data[%0d]", i), 64'(out_data[i*W +: W]), 64'(ed));
      check($sformatf("xfer_count[%0d]", i), 64'(xfer_count[i*CW +: CW]), 64'(mcnt[i] % (1 << CW)));
    end
    if (reset_n) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_q[i].size() > 0 && out_ready[i]) begin
          void'(exp_q[i].pop_front());
          mcnt[i]++;
        end
      end
      if (flush) begin
        for (int i = 0; i < 4; i++) exp_q[i].delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs; after the monitor runs, check in_ready and push accepts.
  task automatic cycle(input logic v, input logic [1:0] a, input logic [W-1:0] d,
                       input logic [3:0] rdy, input logic fl);
    logic mr;
    @(posedge clk);
    #1;
    in_valid   = v;
    in_address = a;
    in_data    = d;
    out_ready  = rdy;
    flush      = fl;
    @(negedge clk);
    #1;
    mr = reset_n && !flush && (exp_q[in_address].size() == 0 || out_ready[in_address]);
    check("in_ready", 64'(in_ready), 64'(mr));
    if (in_valid && mr) begin
      exp_q[in_address].push_back(in_data);
      mdata[in_address] = in_data;
    end
  endtask

  // Assert reset between clock edges and verify outputs clear before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_clear();
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst xfer_count", 64'(xfer_count), 64'(0));
    check("rst out_data_lo", out_data[63:0], 64'(0));
    check("rst out_data_hi", out_data[127:64], 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(0));
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    flush     = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    reset_n    = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b1;
    in_address = 2'd2;
    in_data    = $urandom;
    out_ready  = 4'b0000;
    #2;
    check("reset in_ready", 64'(in_ready), 64'(0));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset out_data", out_data[63:0] | out_data[127:64], 64'(0));
    check("reset xfer_count", 64'(xfer_count), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b1;

    // Stall on channel 1, other channels still accepted.
    cycle(1'b1, 2'd1, 32'hDEADBEEF, 4'b0000, 1'b0);
    cycle(1'b1, 2'd1, 32'hCAFEF00D, 4'b0000, 1'b0);
    check("stall out_valid", 64'(out_valid), 64'(4'b0010));
    check("stall slice1", 64'(out_data[1*W +: W]), 64'(32'hDEADBEEF));
    check("stall in_ready", 64'(in_ready), 64'(0));
    cycle(1'b1, 2'd3, 32'h12345678, 4'b0000, 1'b0);
    cycle(1'b0, 2'd0, $urandom, 4'b0000, 1'b0);
    check("two valid", 64'(out_valid), 64'(4'b1010));
    cycle(1'b0, 2'd0, $urandom, 4'b1010, 1'b0);

    // Full-rate stream into channel 0.
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 2'd0, W'(k), 4'b0001, 1'b0);
      check("stream in_ready", 64'(in_ready), 64'(1));
    end
    cycle(1'b0, 2'd0, $urandom, 4'b0001, 1'b0);
    cycle(1'b0, 2'd0, $urandom, 4'b0000, 1'b0);
    check("stream count0", 64'(xfer_count[0 +: CW]), 64'(4));

    // Simultaneous load and drain on channel 2.
    cycle(1'b1, 2'd2, 32'hA, 4'b0000, 1'b0);
    cycle(1'b1, 2'd2, 32'hB, 4'b0100, 1'b0);
    check("ld+dr in_ready", 64'(in_ready), 64'(1));
    cycle(1'b0, 2'd0, $urandom, 4'b0000, 1'b0);
    check("ld+dr valid2", 64'(out_valid[2]), 64'(1));
    check("ld+dr slice2", 64'(out_data[2*W +: W]), 64'(32'hB));
    check("ld+dr count2", 64'(xfer_count[2*CW +: CW]), 64'(1));
    cycle(1'b0, 2'd0, $urandom, 4'b0100, 1'b0);

    // Counter wrap on channel 3 after 256 drains.
    async_reset();
    for (int k = 0; k < 256; k++) cycle(1'b1, 2'd3, $urandom, 4'b1000, 1'b0);
    cycle(1'b0, 2'd0, $urandom, 4'b1000, 1'b0);
    cycle(1'b0, 2'd0, $urandom, 4'b0000, 1'b0);
    check("wrap count3", 64'(xfer_count[3*CW +: CW]), 64'(0));
    cycle(1'b1, 2'd3, $urandom, 4'b1000, 1'b0);
    cycle(1'b0, 2'd0, $urandom, 4'b1000, 1'b0);
    cycle(1'b0, 2'd0, $urandom, 4'b0000, 1'b0);
    check("wrap+1 count3", 64'(xfer_count[3*CW +: CW]), 64'(1));

    // Fill everything, then flush with in_valid high.
    for (int c = 0; c < 4; c++) cycle(1'b1, 2'(c), $urandom, 4'b0000, 1'b0);
    cycle(1'b1, 2'd0, $urandom, 4'b0000, 1'b1);
    check("flush in_ready", 64'(in_ready), 64'(0));
    check("flush pre valid", 64'(out_valid), 64'(4'b1111));
    cycle(1'b0, 2'd0, $urandom, 4'b0000, 1'b0);
    check("flush post valid", 64'(out_valid), 64'(0));

    // Randomized traffic with occasional flush.
    for (int k = 0; k < 1500; k++) begin
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset in the middle of a stream.
    for (int k = 0; k < 3; k++) cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, 4'b0101, 1'b0);
    async_reset();
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    cycle(1'b0, 2'd0, $urandom, 4'b1111, 1'b0);
    cycle(1'b0, 2'd0, $urandom, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
